// File: rtl/fma_pkg.sv
// Shared types and constants for the FMA_cal arbiter/sequencer.
package fma_pkg;

  localparam int unsigned BW_EXP   = 8;
  localparam int unsigned BW_MAN   = 9;
  localparam int unsigned BW_ALIGN = 9;
  localparam int unsigned BW_TAG   = 4;
  localparam int unsigned BW_MODE  = 5;

  // Encoded operand width: exponent plus mantissa fields.
  function automatic int unsigned op_width(input int unsigned bw_exp, input int unsigned bw_man);
    return bw_exp + bw_man;
  endfunction

  // FMA_cal result width.
  function automatic int unsigned z_width(input int unsigned bw_exp, input int unsigned bw_man);
    return 2 * bw_man + bw_exp + 3;
  endfunction

  localparam int unsigned BW_OP = op_width(BW_EXP, BW_MAN);
  localparam int unsigned BW_Z  = z_width(BW_EXP, BW_MAN);

  localparam logic [BW_MODE-1:0] MODE_SUB = 5'b00001;
  localparam logic [BW_MODE-1:0] MODE_MUL = 5'b00010;
  localparam logic [BW_MODE-1:0] MODE_FMA = 5'b00100;
  localparam logic [BW_MODE-1:0] MODE_ADD = 5'b01000;
  localparam logic [BW_MODE-1:0] MODE_EXP = 5'b10000;

  typedef struct packed {
    logic [BW_Z-1:0]   z;
    logic [BW_EXP-1:0] scale;
    logic [BW_TAG-1:0] tag;
    logic              err;
  } rsp_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A mode is legal only when exactly one bit is set.
  function automatic logic mode_legal(input logic [BW_MODE-1:0] mode);
    return $countones(mode) == 1;
  endfunction

endpackage

// File: rtl/fma_rsp_fifo.sv
// Synchronous response FIFO of rsp_t; writer guarantees it is never written when full.
module fma_rsp_fifo
  import fma_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  rsp_t                       i_wr_data,
  input  logic                       i_rd_en,
  output rsp_t                       o_rd_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  rsp_t            r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_rd;

  assign w_rd      = i_rd_en & (r_count != '0);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage array, written without reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd)    r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_wr_en, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fma_arb_seq.sv
// Two-requester round-robin sequencer sharing one FMA_cal datapath with credit-based issue.
// Optional build macro FMA_ARB_PERF_EN adds saturating busy/stall performance counters.
module fma_arb_seq
  import fma_pkg::*;
#(
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [BW_MODE-1:0]    req0_mode,
  input  logic [BW_OP-1:0]      req0_a,
  input  logic [BW_OP-1:0]      req0_b,
  input  logic [BW_OP-1:0]      req0_c,
  input  logic [BW_ALIGN-1:0]   req0_align,
  input  logic [BW_TAG-1:0]     req0_tag,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [BW_MODE-1:0]    req1_mode,
  input  logic [BW_OP-1:0]      req1_a,
  input  logic [BW_OP-1:0]      req1_b,
  input  logic [BW_OP-1:0]      req1_c,
  input  logic [BW_ALIGN-1:0]   req1_align,
  input  logic [BW_TAG-1:0]     req1_tag,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [BW_Z-1:0]       rsp0_z,
  output logic [BW_EXP-1:0]     rsp0_scale,
  output logic [BW_TAG-1:0]     rsp0_tag,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [BW_Z-1:0]       rsp1_z,
  output logic [BW_EXP-1:0]     rsp1_scale,
  output logic [BW_TAG-1:0]     rsp1_tag,
  output logic                  rsp1_err,
  output logic [BW_MODE-1:0]    fma_mode,
  output logic [BW_OP-1:0]      fma_a,
  output logic [BW_OP-1:0]      fma_b,
  output logic [BW_OP-1:0]      fma_c,
  output logic [BW_ALIGN-1:0]   fma_align,
  input  logic [BW_EXP-1:0]     fma_scale,
  input  logic [BW_Z-1:0]       fma_z,
  input  logic                  flush,
  output logic                  flush_done
`ifdef FMA_ARB_PERF_EN
  ,
  output logic [31:0]           perf_busy,
  output logic [31:0]           perf_stall0,
  output logic [31:0]           perf_stall1
`endif
);

  localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rr;
  logic                 r_iss_vld;
  logic                 r_iss_id;
  logic                 r_iss_err;
  logic [BW_TAG-1:0]    r_iss_tag;
  logic [BW_EXP-1:0]    r_iss_scale;

  logic [CW-1:0]        w_cnt0, w_cnt1;
  logic                 w_empty0, w_empty1;
  logic                 w_credit0, w_credit1;
  logic                 w_run, w_elig0, w_elig1, w_gnt0, w_gnt1, w_issue, w_legal;
  logic [BW_MODE-1:0]   w_mode;
  logic [BW_OP-1:0]     w_a, w_b, w_c;
  logic [BW_ALIGN-1:0]  w_align;
  logic [BW_TAG-1:0]    w_tag;
  rsp_t                 w_wdata, w_rd0, w_rd1;
  logic                 w_wr0, w_wr1;

  // Credit: a response slot must be free counting both stored and in-flight results.
  assign w_credit0 = (w_cnt0 + CW'(r_iss_vld & ~r_iss_id)) < CW'(RSP_DEPTH);
  assign w_credit1 = (w_cnt1 + CW'(r_iss_vld &  r_iss_id)) < CW'(RSP_DEPTH);

  // Round-robin grant; reset forces no grant so ready and fma_* fall to zero immediately.
  assign w_run   = (r_state == ST_RUN) & ~rst;
  assign w_elig0 = w_run & req0_valid & w_credit0;
  assign w_elig1 = w_run & req1_valid & w_credit1;
  assign w_gnt0  = w_elig0 & (~w_elig1 | ~r_rr);
  assign w_gnt1  = w_elig1 & (~w_elig0 |  r_rr);
  assign w_issue = w_gnt0 | w_gnt1;
  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // Operand mux toward FMA_cal; idle cycles and illegal modes present mode 0.
  always_comb begin
    w_mode    = w_gnt1 ? req1_mode  : req0_mode;
    w_a       = w_gnt1 ? req1_a     : req0_a;
    w_b       = w_gnt1 ? req1_b     : req0_b;
    w_c       = w_gnt1 ? req1_c     : req0_c;
    w_align   = w_gnt1 ? req1_align : req0_align;
    w_tag     = w_gnt1 ? req1_tag   : req0_tag;
    w_legal   = mode_legal(w_mode);
    fma_mode  = '0;
    fma_a     = '0;
    fma_b     = '0;
    fma_c     = '0;
    fma_align = '0;
    if (w_issue) begin
      fma_mode  = w_legal ? w_mode : '0;
      fma_a     = w_a;
      fma_b     = w_b;
      fma_c     = w_c;
      fma_align = w_align;
    end
  end

  // FSM state, rr pointer and one-stage issue pipe carrying id/tag/err/scale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_rr        <= 1'b0;
      r_iss_vld   <= 1'b0;
      r_iss_id    <= 1'b0;
      r_iss_err   <= 1'b0;
      r_iss_tag   <= '0;
      r_iss_scale <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_iss_vld <= w_issue;
      if (w_elig0 & w_elig1) r_rr <= ~r_rr;
      if (w_issue) begin
        r_iss_id    <= w_gnt1;
        r_iss_err   <= ~w_legal;
        r_iss_tag   <= w_tag;
        r_iss_scale <= w_legal ? fma_scale : '0;
      end
    end
  end

  // Next state and flush_done decode.
  always_comb begin
    w_state_nxt = r_state;
    flush_done  = 1'b0;
    case (r_state)
      ST_RUN:   if (flush) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_iss_vld && w_empty0 && w_empty1) w_state_nxt = ST_DONE;
      ST_DONE: begin
        flush_done  = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // Result write: FMA_cal z arrives one cycle after issue.
  always_comb begin
    w_wdata.z     = r_iss_err ? '0 : fma_z;
    w_wdata.scale = r_iss_scale;
    w_wdata.tag   = r_iss_tag;
    w_wdata.err   = r_iss_err;
    w_wr0         = r_iss_vld & ~r_iss_id;
    w_wr1         = r_iss_vld &  r_iss_id;
  end

  fma_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr0),
    .i_wr_data (w_wdata),
    .i_rd_en   (rsp0_ready),
    .o_rd_data (w_rd0),
    .o_empty   (w_empty0),
    .o_count   (w_cnt0)
  );

  fma_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr1),
    .i_wr_data (w_wdata),
    .i_rd_en   (rsp1_ready),
    .o_rd_data (w_rd1),
    .o_empty   (w_empty1),
    .o_count   (w_cnt1)
  );

  assign rsp0_valid = ~w_empty0;
  assign rsp0_z     = w_rd0.z;
  assign rsp0_scale = w_rd0.scale;
  assign rsp0_tag   = w_rd0.tag;
  assign rsp0_err   = w_rd0.err;
  assign rsp1_valid = ~w_empty1;
  assign rsp1_z     = w_rd1.z;
  assign rsp1_scale = w_rd1.scale;
  assign rsp1_tag   = w_rd1.tag;
  assign rsp1_err   = w_rd1.err;

`ifdef FMA_ARB_PERF_EN
  // Saturating performance counters, cleared on reset and on flush completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy   <= '0;
      perf_stall0 <= '0;
      perf_stall1 <= '0;
    end else if (flush_done) begin
      perf_busy   <= '0;
      perf_stall0 <= '0;
      perf_stall1 <= '0;
    end else begin
      if (w_issue && (perf_busy != '1))                     perf_busy   <= perf_busy + 32'd1;
      if (req0_valid && !req0_ready && (perf_stall0 != '1)) perf_stall0 <= perf_stall0 + 32'd1;
      if (req1_valid && !req1_ready && (perf_stall1 != '1)) perf_stall1 <= perf_stall1 + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fma_arb_seq.sv
// Self-checking bench for fma_arb_seq with a behavioural FMA_cal stub and per-requester scoreboards.
module tb_fma_arb_seq;
  import fma_pkg::*;

  typedef struct packed {
    logic [BW_MODE-1:0]  mode;
    logic [BW_OP-1:0]    a;
    logic [BW_OP-1:0]    b;
    logic [BW_OP-1:0]    c;
    logic [BW_ALIGN-1:0] align;
    logic [BW_TAG-1:0]   tag;
  } cmd_t;

  typedef struct packed {
    cmd_t               cmd;
    logic [BW_MODE-1:0] exp_fma_mode;
    logic               exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  cmd_t d0, d1;
  logic rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [BW_Z-1:0]     rsp0_z, rsp1_z;
  logic [BW_EXP-1:0]   rsp0_scale, rsp1_scale;
  logic [BW_TAG-1:0]   rsp0_tag, rsp1_tag;
  logic                rsp0_err, rsp1_err;
  logic [BW_MODE-1:0]  fma_mode;
  logic [BW_OP-1:0]    fma_a, fma_b, fma_c;
  logic [BW_ALIGN-1:0] fma_align;
  logic [BW_EXP-1:0]   fma_scale;
  logic [BW_Z-1:0]     fma_z;
  logic                flush, flush_done;
`ifdef FMA_ARB_PERF_EN
  logic [31:0] perf_busy, perf_stall0, perf_stall1;
`endif

  cmd_t q_cmd0[$], q_cmd1[$];
  rsp_t sb0[$], sb1[$];
  int   glog[$];
  int   n_pass = 0, n_checks = 0, cyc = 0;
  int   acc_cnt0 = 0, acc_cnt1 = 0, rsp_cnt0 = 0, rsp_cnt1 = 0;
  logic acc0 = 1'b0, acc1 = 1'b0;
  vec_t vt[8];

  always #5 clk = ~clk;

  fma_arb_seq dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(d0.mode),
    .req0_a(d0.a), .req0_b(d0.b), .req0_c(d0.c), .req0_align(d0.align), .req0_tag(d0.tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(d1.mode),
    .req1_a(d1.a), .req1_b(d1.b), .req1_c(d1.c), .req1_align(d1.align), .req1_tag(d1.tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(rsp0_z),
    .rsp0_scale(rsp0_scale), .rsp0_tag(rsp0_tag), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(rsp1_z),
    .rsp1_scale(rsp1_scale), .rsp1_tag(rsp1_tag), .rsp1_err(rsp1_err),
    .fma_mode(fma_mode), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_align(fma_align), .fma_scale(fma_scale), .fma_z(fma_z),
    .flush(flush), .flush_done(flush_done)
`ifdef FMA_ARB_PERF_EN
    , .perf_busy(perf_busy), .perf_stall0(perf_stall0), .perf_stall1(perf_stall1)
`endif
  );

  // Stand-in FMA_cal result: any deterministic mix of all inputs, nonzero even for mode 0.
  function automatic logic [BW_Z-1:0] zf(input logic [BW_MODE-1:0] m, input logic [BW_OP-1:0] a,
                                         input logic [BW_OP-1:0] b, input logic [BW_OP-1:0] c,
                                         input logic [BW_ALIGN-1:0] al);
    return BW_Z'(a) ^ (BW_Z'(b) << 6) ^ (BW_Z'(c) << 11) ^ (BW_Z'(al) << 15) ^ (BW_Z'(m) << 24)
           ^ BW_Z'(32'h1357);
  endfunction

  function automatic logic [BW_EXP-1:0] sf(input logic [BW_OP-1:0] a, input logic [BW_OP-1:0] b);
    return BW_EXP'(a[7:0] ^ b[16:9] ^ 8'hA5);
  endfunction

  function automatic logic legal(input logic [BW_MODE-1:0] m);
    int n;
    n = 0;
    for (int i = 0; i < BW_MODE; i++) n += int'(m[i]);
    return n == 1;
  endfunction

  function automatic rsp_t exp_rsp(input cmd_t c);
    rsp_t r;
    r.tag = c.tag;
    if (legal(c.mode)) begin
      r.z = zf(c.mode, c.a, c.b, c.c, c.align); r.scale = sf(c.a, c.b); r.err = 1'b0;
    end else begin
      r.z = '0; r.scale = '0; r.err = 1'b1;
    end
    return r;
  endfunction

  // FMA_cal stub: scale is combinational, z registered one cycle.
  assign fma_scale = sf(fma_a, fma_b);
  always @(posedge clk) fma_z <= zf(fma_mode, fma_a, fma_b, fma_c, fma_align);

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Command drivers: pop on the handshake seen last cycle, then present the next head.
  always @(posedge clk) begin
    #1;
    if (acc0 && q_cmd0.size() > 0) void'(q_cmd0.pop_front());
    if (acc1 && q_cmd1.size() > 0) void'(q_cmd1.pop_front());
    req0_valid = (q_cmd0.size() > 0);
    req1_valid = (q_cmd1.size() > 0);
    d0 = (q_cmd0.size() > 0) ? q_cmd0[0] : '0;
    d1 = (q_cmd1.size() > 0) ? q_cmd1[0] : '0;
  end

  // Monitor on the falling edge: scoreboard push on accept, pop/compare on response.
  always @(negedge clk) begin
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) chk("one_issue", 64'(req0_ready && req1_ready), 64'd0);
      if (req0_valid && req0_ready) begin
        acc0 = 1'b1; acc_cnt0++; sb0.push_back(exp_rsp(d0)); glog.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        acc1 = 1'b1; acc_cnt1++; sb1.push_back(exp_rsp(d1)); glog.push_back(1);
      end
      if (rsp0_valid && rsp0_ready) begin
        rsp_cnt0++;
        chk("rsp0_expected", 64'(sb0.size() > 0), 64'd1);
        if (sb0.size() > 0) chk("rsp0", 64'({rsp0_z, rsp0_scale, rsp0_tag, rsp0_err}), 64'(sb0.pop_front()));
      end
      if (rsp1_valid && rsp1_ready) begin
        rsp_cnt1++;
        chk("rsp1_expected", 64'(sb1.size() > 0), 64'd1);
        if (sb1.size() > 0) chk("rsp1", 64'({rsp1_z, rsp1_scale, rsp1_tag, rsp1_err}), 64'(sb1.pop_front()));
      end
    end
  end

  task automatic wait_acc(input int id, input string nm, output int t);
    t = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (id == 0 ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
        t = cyc; break;
      end
    end
    chk(nm, 64'(t >= 0), 64'd1);
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (q_cmd0.size() == 0 && q_cmd1.size() == 0 && sb0.size() == 0 && sb1.size() == 0 &&
          !req0_valid && !req1_valid) begin
        ok = 1'b1; break;
      end
    end
    chk(nm, 64'(ok), 64'd1);
  endtask

  function automatic cmd_t mk(input logic [BW_MODE-1:0] m, input int seed, input logic [BW_TAG-1:0] tag);
    cmd_t c;
    c.mode = m; c.a = BW_OP'(seed * 37 + 5); c.b = BW_OP'(seed * 1031 + 77);
    c.c = BW_OP'(seed * 211 + 9); c.align = BW_ALIGN'(seed * 3); c.tag = tag;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t_acc, t_rsp, base, rbase, pulses, sb_at_done, rv_at_done;
    rst = 1'b1; flush = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; d0 = '0; d1 = '0;

    // Reset state with a request pending.
    q_cmd0.push_back(mk(MODE_MUL, 1, 4'h3));
    repeat (3) @(negedge clk);
    chk("rst_req0_valid_driven", 64'(req0_valid), 64'd1);
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    chk("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    chk("rst_fma_mode", 64'(fma_mode), 64'd0);
    chk("rst_fma_a", 64'(fma_a), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    q_cmd0.delete();
    @(posedge clk); #2; rst = 1'b0;

    // Accept-to-response latency is two cycles, tag echoed.
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    q_cmd0.push_back('{mode: MODE_MUL, a: 17'h00100, b: 17'h00100, c: '0, align: '0, tag: 4'h5});
    wait_acc(0, "lat_accept", t_acc);
    t_rsp = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp0_valid) begin t_rsp = cyc; break; end
    end
    chk("lat_cycles", 64'(t_rsp - t_acc), 64'd2);
    chk("lat_tag", 64'(rsp0_tag), 64'h5);
    wait_idle(20, "lat_drain");

    // Mode table: each legal mode plus illegal encodings.
    vt[0] = '{mk(MODE_SUB, 2, 4'h1), MODE_SUB, 1'b0};
    vt[1] = '{mk(MODE_MUL, 3, 4'h2), MODE_MUL, 1'b0};
    vt[2] = '{'{MODE_FMA, 17'h1FFFF, 17'h0ABCD, 17'h12345, 9'h1FF, 4'h3}, MODE_FMA, 1'b0};
    vt[3] = '{mk(MODE_ADD, 4, 4'h4), MODE_ADD, 1'b0};
    vt[4] = '{mk(MODE_EXP, 5, 4'hF), MODE_EXP, 1'b0};
    vt[5] = '{mk(5'b00101, 6, 4'h6), 5'b00000, 1'b1};
    vt[6] = '{mk(5'b00000, 7, 4'h7), 5'b00000, 1'b1};
    vt[7] = '{mk(5'b11111, 8, 4'h8), 5'b00000, 1'b1};
    for (int i = 0; i < 8; i++) begin
      q_cmd0.push_back(vt[i].cmd);
      wait_acc(0, "vec_accept", t_acc);
      chk("vec_fma_mode", 64'(fma_mode), 64'(vt[i].exp_fma_mode));
      chk("vec_fma_c", 64'(fma_c), 64'(vt[i].cmd.c));
      t_rsp = -1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (rsp0_valid) begin t_rsp = cyc; break; end
      end
      chk("vec_rsp_seen", 64'(t_rsp >= 0), 64'd1);
      chk("vec_err", 64'(rsp0_err), 64'(vt[i].exp_err));
    end
    wait_idle(20, "vec_drain");
    chk("idle_fma_mode", 64'(fma_mode), 64'd0);
    chk("idle_fma_a", 64'(fma_a), 64'd0);
    chk("idle_rsp0_valid", 64'(rsp0_valid), 64'd0);

    // Both requesters continuously valid: grants alternate.
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      q_cmd0.push_back(mk(MODE_FMA, 20 + i, 4'(i)));
      q_cmd1.push_back(mk(MODE_ADD, 40 + i, 4'(8 + i)));
    end
    wait_idle(60, "alt_drain");
    chk("alt_len", 64'(glog.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk("alt_gnt", 64'(glog.size() > i ? glog[i] : 9), 64'(i % 2));

    // Backpressure on rsp1: only two ops fit, nothing lost once released.
    rsp1_ready = 1'b0;
    base = acc_cnt1; rbase = rsp_cnt1;
    for (int i = 0; i < 4; i++) q_cmd1.push_back(mk(MODE_SUB, 60 + i, 4'(i + 2)));
    repeat (10) @(negedge clk);
    chk("bp_accepted", 64'(acc_cnt1 - base), 64'd2);
    chk("bp_valid_held", 64'(req1_valid), 64'd1);
    chk("bp_ready_low", 64'(req1_ready), 64'd0);
    chk("bp_rsp_valid", 64'(rsp1_valid), 64'd1);
    rsp1_ready = 1'b1;
    wait_idle(40, "bp_drain");
    chk("bp_total_acc", 64'(acc_cnt1 - base), 64'd4);
    chk("bp_total_rsp", 64'(rsp_cnt1 - rbase), 64'd4);

    // Flush with ops in flight: ready drops, one flush_done after drain, then RUN again.
    base = acc_cnt0;
    for (int i = 0; i < 4; i++) q_cmd0.push_back(mk(MODE_MUL, 80 + i, 4'(i + 9)));
    wait_acc(0, "flush_first_acc", t_acc);
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("flush_valid_held", 64'(req0_valid), 64'd1);
    chk("flush_ready_low", 64'(req0_ready), 64'd0);
    pulses = 0; sb_at_done = -1; rv_at_done = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (flush_done) begin
        pulses++;
        if (pulses == 1) begin sb_at_done = sb0.size(); rv_at_done = int'(rsp0_valid); end
      end
    end
    chk("flush_pulses", 64'(pulses), 64'd1);
    chk("flush_sb_empty", 64'(sb_at_done), 64'd0);
    chk("flush_rsp_idle", 64'(rv_at_done), 64'd0);
    wait_idle(40, "flush_resume");
    chk("flush_total_acc", 64'(acc_cnt0 - base), 64'd4);

    // Reset mid-burst: asynchronous clear, FIFOs empty, rr back to req0.
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    q_cmd0.push_back(mk(MODE_ADD, 100, 4'h1));
    for (int i = 0; i < 3; i++) q_cmd1.push_back(mk(MODE_EXP, 110 + i, 4'(i)));
    repeat (8) @(negedge clk);
    chk("pre_rst_rsp1_valid", 64'(rsp1_valid), 64'd1);
    @(posedge clk); #3; rst = 1'b1; #1;
    chk("async_rsp0_valid", 64'(rsp0_valid), 64'd0);
    chk("async_rsp1_valid", 64'(rsp1_valid), 64'd0);
    chk("async_req1_ready", 64'(req1_ready), 64'd0);
    chk("async_fma_mode", 64'(fma_mode), 64'd0);
    q_cmd0.delete(); q_cmd1.delete(); sb0.delete(); sb1.delete();
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    chk("post_rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    glog.delete();
    q_cmd0.push_back(mk(MODE_SUB, 120, 4'hA));
    q_cmd1.push_back(mk(MODE_SUB, 121, 4'hB));
    wait_idle(30, "post_rst_drain");
    chk("post_rst_first_gnt", 64'(glog.size() > 0 ? glog[0] : 9), 64'd0);
    chk("post_rst_second_gnt", 64'(glog.size() > 1 ? glog[1] : 9), 64'd1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
